shifter_sched: RTL and testbench
================================

Name: shifter_sched

Overview:
- Sequencer for the sparsity shifter: pulls activation/weight tiles (LANES lanes of IL+FL-bit signed fixed point) from the tile buffer and issues each tile to the shifter.
- Runs the shifter state handshake (load, wait for input_taken, wait for output_ready), then captures compacted outputs and hands them downstream under valid/ready.
- Sits between the tile buffer and the MAC array; counts tiles per job, reports done and timeout error.

Parameters:
- IL, 4, integer bits per element
- FL, 16, fractional bits per element
- LANES, 16, elements per tile (activations and weights each)
- TILE_W, 16, width of tile count
- TIMEOUT, 64, max cycles waiting on any shifter handshake before error

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  job start pulse; sampled only in IDLE/DONE/ERR
- num_tiles  in  TILE_W  tiles in job; sampled on accepted start
- busy  out  1  high from accepted start until DONE/ERR
- done  out  1  one-cycle pulse when last tile drained
- err  out  1  sticky timeout flag; cleared by reset or accepted start
- tile_valid  in  1  buffer has a tile
- tile_ready  out  1  scheduler accepts tile
- tile_i  in  LANES*(IL+FL)  activations, lane k at bits [k*(IL+FL) +: IL+FL]
- tile_w  in  LANES*(IL+FL)  weights, same packing
- sh_state  out  2  shifter command: 2'b10 = load/compute, 2'b00 = idle
- sh_i, sh_w  out  LANES*(IL+FL) each  registered tile driven to shifter i_k/w_k
- sh_input_taken  in  1  shifter latched inputs
- sh_output_ready  in  1  shifter outputs valid
- sh_oi, sh_ow  in  LANES*(IL+FL) each  compacted shifter outputs
- out_valid  out  1  captured tile available
- out_ready  in  1  MAC array accepts
- out_i, out_w  out  LANES*(IL+FL) each  captured compacted tile
- tiles_done  out  TILE_W  tiles drained in current job

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: FSM=IDLE; busy=0, done=0, err=0, tile_ready=0, sh_state=2'b00, sh_i=sh_w=0, out_valid=0, out_i=out_w=0, tiles_done=0, timeout counter=0.
- FSM states: IDLE, FETCH, ISSUE, WAIT, DRAIN, DONE, ERR.
- IDLE/DONE/ERR: on start, latch num_tiles, clear tiles_done and err, set busy.
  - If num_tiles==0: go to DONE next cycle, pulse done once, busy low in DONE.
  - Otherwise go to FETCH.
- FETCH: tile_ready=1. On tile_valid&tile_ready, register tile_i/tile_w into sh_i/sh_w and go to ISSUE.
- ISSUE: sh_state=2'b10, held from the first ISSUE cycle until sh_input_taken is sampled high; then go to WAIT. sh_i/sh_w held stable throughout.
- WAIT: sh_state=2'b00. On sh_output_ready, capture sh_oi/sh_ow into out_i/out_w, set out_valid, go to DRAIN.
- sh_input_taken and sh_output_ready high in the same ISSUE cycle: go straight to DRAIN with outputs captured; WAIT is skipped.
- DRAIN: out_valid held with out_i/out_w stable until out_ready. On out_valid&out_ready:
  - tiles_done+1;
  - if the new tiles_done==latched num_tiles, go to DONE and pulse done for 1 cycle;
  - else go to FETCH.
- Latency: tile accept to sh_state=10 is 1 cycle; output_ready sample to out_valid is 1 cycle. Minimum per tile is 4 cycles (FETCH, ISSUE, WAIT, DRAIN) with zero-wait handshakes.
- Timeout: counter clears on entry to ISSUE and WAIT and increments each cycle spent there. At TIMEOUT cycles, go to ERR: err=1 (sticky), busy=0, sh_state=00, out_valid=0. FETCH and DRAIN never time out, because upstream/downstream stalls are legal.
- start while busy is ignored.
- Reset mid-job aborts immediately to reset values; no partial tile is emitted.
- tiles_done wraps modulo 2^TILE_W; num_tiles is bounded by the same width, so no overflow within a job.
- No arithmetic on data; the scheduler only moves data bit-exact.

Test Plan:
- num_tiles=1; tile lanes 0,3 = 20'b1111<<10, others 0; shifter input_taken 2 cycles after sh_state=10, output_ready 3 cycles later; out_ready=1 -> sh_state=10 exactly until input_taken, out_i/out_w equal shifter outputs, done pulses once, tiles_done=1, busy low after.
- num_tiles=3, tile_valid toggled 1/0 each cycle, out_ready low 5 cycles per tile -> three tiles emitted in order, each out tile stable while stalled, done after the third, no timeout.
- num_tiles=0, start -> DONE next cycle, done pulse, tile_ready never asserted, sh_state stays 00.
- Shifter never asserts input_taken (TIMEOUT=64) -> err=1 after 64 ISSUE cycles, sh_state=00, busy=0. A new start clears err and the job runs normally.
- input_taken and output_ready in the same cycle -> WAIT skipped, out_valid the next cycle with correct data.
- reset asserted during WAIT of tile 2 of 4 -> all outputs at reset values next cycle. A start with num_tiles=2 then completes with tiles_done=2.

Source files
------------

// File: rtl/shifter_sched.sv
// shifter_sched: sequences tiles from the tile buffer through the sparsity
// shifter handshake and hands the compacted result to the MAC array.
module shifter_sched #(
  parameter int IL      = 4,
  parameter int FL      = 16,
  parameter int LANES   = 16,
  parameter int TILE_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [TILE_W-1:0]           num_tiles,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  input  logic                        tile_valid,
  output logic                        tile_ready,
  input  logic [LANES*(IL+FL)-1:0]    tile_i,
  input  logic [LANES*(IL+FL)-1:0]    tile_w,
  output logic [1:0]                  sh_state,
  output logic [LANES*(IL+FL)-1:0]    sh_i,
  output logic [LANES*(IL+FL)-1:0]    sh_w,
  input  logic                        sh_input_taken,
  input  logic                        sh_output_ready,
  input  logic [LANES*(IL+FL)-1:0]    sh_oi,
  input  logic [LANES*(IL+FL)-1:0]    sh_ow,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*(IL+FL)-1:0]    out_i,
  output logic [LANES*(IL+FL)-1:0]    out_w,
  output logic [TILE_W-1:0]           tiles_done
);

  localparam int DW    = LANES * (IL + FL);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DRAIN, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [TILE_W-1:0] num_q, num_d;
  logic [TILE_W-1:0] tiles_done_q, tiles_done_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DW-1:0]     sh_i_q, sh_i_d, sh_w_q, sh_w_d;
  logic [DW-1:0]     out_i_q, out_i_d, out_w_q, out_w_d;
  logic              tmo_hit;

  // Last allowed handshake cycle: the counter reads 0 on the first cycle in a state.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      tiles_done_q <= '0;
      tmo_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sh_i_q       <= '0;
      sh_w_q       <= '0;
      out_i_q      <= '0;
      out_w_q      <= '0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      tiles_done_q <= tiles_done_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sh_i_q       <= sh_i_d;
      sh_w_q       <= sh_w_d;
      out_i_q      <= out_i_d;
      out_w_q      <= out_w_d;
    end
  end

  // Next-state, counters and data capture.
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    tiles_done_d = tiles_done_q;
    tmo_d        = tmo_q;
    done_d       = 1'b0;
    err_d        = err_q;
    sh_i_d       = sh_i_q;
    sh_w_d       = sh_w_q;
    out_i_d      = out_i_q;
    out_w_d      = out_w_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          num_d        = num_tiles;
          tiles_done_d = '0;
          err_d        = 1'b0;
          if (num_tiles == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (tile_valid) begin
          sh_i_d  = tile_i;
          sh_w_d  = tile_w;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d = tmo_q + 1'b1;
        if (sh_input_taken && sh_output_ready) begin
          out_i_d = sh_oi;
          out_w_d = sh_ow;
          state_d = S_DRAIN;
        end else if (sh_input_taken) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (sh_output_ready) begin
          out_i_d = sh_oi;
          out_w_d = sh_ow;
          state_d = S_DRAIN;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          tiles_done_d = tiles_done_q + TILE_W'(1);
          if (tiles_done_d == num_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    busy       = 1'b0;
    tile_ready = 1'b0;
    sh_state   = 2'b00;
    out_valid  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        busy       = 1'b1;
        tile_ready = 1'b1;
      end
      S_ISSUE: begin
        busy     = 1'b1;
        sh_state = 2'b10;
      end
      S_WAIT:  busy = 1'b1;
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign done       = done_q;
  assign err        = err_q;
  assign sh_i       = sh_i_q;
  assign sh_w       = sh_w_q;
  assign out_i      = out_i_q;
  assign out_w      = out_w_q;
  assign tiles_done = tiles_done_q;

endmodule

// File: tb/tb_shifter_sched.sv
// Directed bench for shifter_sched: drives the tile buffer, shifter and MAC
// handshakes cycle by cycle and checks against hand-computed values.
module tb_shifter_sched;
  localparam int IL = 4, FL = 16, LANES = 16, TILE_W = 16, TIMEOUT = 64;
  localparam int EW = IL + FL;
  localparam int DW = LANES * EW;

  logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [TILE_W-1:0] num_tiles = '0;
  logic              busy, done, err, tile_ready, out_valid;
  logic              tile_valid = 1'b0, out_ready = 1'b0;
  logic              sh_input_taken = 1'b0, sh_output_ready = 1'b0;
  logic [DW-1:0]     tile_i = '0, tile_w = '0, sh_oi = '0, sh_ow = '0;
  logic [DW-1:0]     sh_i, sh_w, out_i, out_w;
  logic [1:0]        sh_state;
  logic [TILE_W-1:0] tiles_done;
  int                vecs = 0, miscompares = 0;

  always #5 clk = ~clk;

  shifter_sched #(.IL(IL), .FL(FL), .LANES(LANES), .TILE_W(TILE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done), .err(err),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_i(tile_i), .tile_w(tile_w),
    .sh_state(sh_state), .sh_i(sh_i), .sh_w(sh_w),
    .sh_input_taken(sh_input_taken), .sh_output_ready(sh_output_ready),
    .sh_oi(sh_oi), .sh_ow(sh_ow),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_w(out_w),
    .tiles_done(tiles_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned seed);
    logic [DW-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < LANES; k++) v[k*EW +: EW] = EW'(seed * 4099 + k * 17 + 1);
    return v;
  endfunction

  // Zero-wait tile from FETCH through drain; stimulus only.
  task automatic quick_tile(input int unsigned seed);
    tile_valid = 1'b1; tile_i = pat(seed); tile_w = pat(seed + 1); tick();
    tile_valid = 1'b0; sh_input_taken = 1'b1; tick();
    sh_input_taken = 1'b0; sh_output_ready = 1'b1; sh_oi = pat(seed + 2); sh_ow = pat(seed + 3); tick();
    sh_output_ready = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    vecs++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vecs++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", done); end
    vecs++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b want 0", err); end
    vecs++; if (tile_ready !== 1'b0) begin miscompares++; $display("FAIL reset_tile_ready: got %0b want 0", tile_ready); end
    vecs++; if (sh_state !== 2'b00) begin miscompares++; $display("FAIL reset_sh_state: got %b want 00", sh_state); end
    vecs++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    vecs++; if ({sh_i, sh_w, out_i, out_w} !== '0) begin miscompares++; $display("FAIL reset_data: sh_i %h out_i %h want 0", sh_i, out_i); end
    vecs++; if (tiles_done !== '0) begin miscompares++; $display("FAIL reset_tiles_done: got %0d want 0", tiles_done); end
    reset = 1'b0; tick();
    vecs++; if ({busy, tile_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_idle: busy/tile_ready %b want 00", {busy, tile_ready}); end
  endtask

  task automatic test_single();
    logic [DW-1:0] ti, tw, oi, ow;
    ti = '0; ti[0 +: EW] = 20'h03C00; ti[3*EW +: EW] = 20'h03C00;
    tw = '0; tw[0 +: EW] = 20'hFC400; tw[3*EW +: EW] = 20'hFC400;
    oi = '0; oi[0 +: EW] = 20'h03C00; oi[EW +: EW] = 20'h03C00;
    ow = '0; ow[0 +: EW] = 20'hFC400; ow[EW +: EW] = 20'hFC400;
    out_ready = 1'b1; start = 1'b1; num_tiles = 16'd1; tick();
    start = 1'b0;
    vecs++; if ({busy, tile_ready, sh_state} !== 4'b1100) begin miscompares++; $display("FAIL single_fetch: busy/rdy/sh %b want 1100", {busy, tile_ready, sh_state}); end
    tile_valid = 1'b1; tile_i = ti; tile_w = tw; tick();
    tile_valid = 1'b0; tile_i = '0; tile_w = '0;
    vecs++; if (sh_i !== ti) begin miscompares++; $display("FAIL single_sh_i: got %h want %h", sh_i, ti); end
    vecs++; if (sh_w !== tw) begin miscompares++; $display("FAIL single_sh_w: got %h want %h", sh_w, tw); end
    vecs++; if (tile_ready !== 1'b0) begin miscompares++; $display("FAIL single_tile_ready_issue: got %0b want 0", tile_ready); end
    for (int unsigned c = 0; c < 3; c++) begin
      vecs++; if (sh_state !== 2'b10) begin miscompares++; $display("FAIL single_issue_c%0d: sh_state %b want 10", c, sh_state); end
      if (c == 2) sh_input_taken = 1'b1;
      tick();
    end
    sh_input_taken = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      vecs++; if ({sh_state, out_valid} !== 3'b000) begin miscompares++; $display("FAIL single_wait_c%0d: sh_state/out_valid %b want 000", c, {sh_state, out_valid}); end
      if (c == 2) begin sh_output_ready = 1'b1; sh_oi = oi; sh_ow = ow; end
      tick();
    end
    sh_output_ready = 1'b0; sh_oi = '0; sh_ow = '0;
    vecs++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid: got %0b want 1", out_valid); end
    vecs++; if (out_i !== oi) begin miscompares++; $display("FAIL single_out_i: got %h want %h", out_i, oi); end
    vecs++; if (out_w !== ow) begin miscompares++; $display("FAIL single_out_w: got %h want %h", out_w, ow); end
    vecs++; if (sh_i !== ti) begin miscompares++; $display("FAIL single_sh_i_hold: got %h want %h", sh_i, ti); end
    tick();
    vecs++; if (done !== 1'b1) begin miscompares++; $display("FAIL single_done: got %0b want 1", done); end
    vecs++; if (tiles_done !== 16'd1) begin miscompares++; $display("FAIL single_tiles_done: got %0d want 1", tiles_done); end
    vecs++; if ({busy, out_valid} !== 2'b00) begin miscompares++; $display("FAIL single_idle: busy/out_valid %b want 00", {busy, out_valid}); end
    tick();
    vecs++; if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse: got %0b want 0", done); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    out_ready = 1'b0; start = 1'b1; num_tiles = 16'd3; tick();
    start = 1'b0;
    vecs++; if ({busy, tiles_done} !== {1'b1, 16'd0}) begin miscompares++; $display("FAIL stall_start: busy %0b tiles_done %0d want 1 0", busy, tiles_done); end
    for (int unsigned n = 0; n < 3; n++) begin
      tile_valid = 1'b0; start = 1'b1; num_tiles = 16'd0; tick();
      start = 1'b0;
      vecs++; if ({busy, tile_ready, done} !== 3'b110) begin miscompares++; $display("FAIL stall_fetch_t%0d: busy/rdy/done %b want 110", n, {busy, tile_ready, done}); end
      tile_valid = 1'b1; tile_i = pat(n * 10 + 100); tile_w = pat(n * 10 + 101); tick();
      tile_valid = 1'b0;
      vecs++; if (sh_state !== 2'b10) begin miscompares++; $display("FAIL stall_issue_t%0d: sh_state %b want 10", n, sh_state); end
      sh_input_taken = 1'b1; tick();
      sh_input_taken = 1'b0; sh_output_ready = 1'b1; sh_oi = pat(n * 10 + 102); sh_ow = pat(n * 10 + 103); tick();
      sh_output_ready = 1'b0; sh_oi = pat(999); sh_ow = pat(998);
      for (int unsigned s = 0; s < 5; s++) begin
        vecs++;
        if ({out_valid, out_i, out_w} !== {1'b1, pat(n * 10 + 102), pat(n * 10 + 103)}) begin
          miscompares++; $display("FAIL stall_hold_t%0d_s%0d: out_valid %0b out_i %h want 1 %h", n, s, out_valid, out_i, pat(n * 10 + 102));
        end
        tick();
      end
      out_ready = 1'b1; tick();
      out_ready = 1'b0;
      vecs++; if (tiles_done !== TILE_W'(n + 1)) begin miscompares++; $display("FAIL stall_count_t%0d: got %0d want %0d", n, tiles_done, n + 1); end
      if (n < 2) begin
        vecs++; if ({tile_ready, done} !== 2'b10) begin miscompares++; $display("FAIL stall_next_t%0d: rdy/done %b want 10", n, {tile_ready, done}); end
      end else begin
        vecs++; if ({done, busy} !== 2'b10) begin miscompares++; $display("FAIL stall_done: done/busy %b want 10", {done, busy}); end
      end
    end
    vecs++; if (err !== 1'b0) begin miscompares++; $display("FAIL stall_no_err: got %0b want 0", err); end
  endtask

  task automatic test_zero();
    start = 1'b1; num_tiles = 16'd0; tick();
    start = 1'b0;
    vecs++; if ({done, busy, tile_ready, sh_state} !== 5'b10000) begin miscompares++; $display("FAIL zero_done: done/busy/rdy/sh %b want 10000", {done, busy, tile_ready, sh_state}); end
    vecs++; if (tiles_done !== 16'd0) begin miscompares++; $display("FAIL zero_tiles_done: got %0d want 0", tiles_done); end
    tick();
    vecs++; if ({done, tile_ready, sh_state} !== 4'b0000) begin miscompares++; $display("FAIL zero_after: done/rdy/sh %b want 0000", {done, tile_ready, sh_state}); end
  endtask

  task automatic test_timeout();
    start = 1'b1; num_tiles = 16'd1; tick();
    start = 1'b0; tile_valid = 1'b1; tile_i = pat(40); tile_w = pat(41); tick();
    tile_valid = 1'b0;
    for (int unsigned c = 0; c < 64; c++) begin
      vecs++; if ({sh_state, err} !== 3'b100) begin miscompares++; $display("FAIL timeout_issue_c%0d: sh_state/err %b want 100", c, {sh_state, err}); end
      tick();
    end
    vecs++; if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %0b want 1", err); end
    vecs++; if ({sh_state, busy, out_valid} !== 4'b0000) begin miscompares++; $display("FAIL timeout_outputs: sh/busy/out_valid %b want 0000", {sh_state, busy, out_valid}); end
    tick();
    vecs++; if ({err, tile_ready} !== 2'b10) begin miscompares++; $display("FAIL timeout_sticky: err/rdy %b want 10", {err, tile_ready}); end
  endtask

  task automatic test_same_cycle();
    start = 1'b1; num_tiles = 16'd1; tick();
    start = 1'b0;
    vecs++; if ({err, busy} !== 2'b01) begin miscompares++; $display("FAIL same_err_clear: err/busy %b want 01", {err, busy}); end
    tile_valid = 1'b1; tile_i = pat(50); tile_w = pat(51); tick();
    tile_valid = 1'b0;
    sh_input_taken = 1'b1; sh_output_ready = 1'b1; sh_oi = pat(52); sh_ow = pat(53); tick();
    sh_input_taken = 1'b0; sh_output_ready = 1'b0; sh_oi = '0; sh_ow = '0;
    vecs++; if ({sh_state, out_valid} !== 3'b001) begin miscompares++; $display("FAIL same_drain: sh/out_valid %b want 001", {sh_state, out_valid}); end
    vecs++; if ({out_i, out_w} !== {pat(52), pat(53)}) begin miscompares++; $display("FAIL same_data: out_i %h want %h", out_i, pat(52)); end
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    vecs++; if ({done, tiles_done} !== {1'b1, 16'd1}) begin miscompares++; $display("FAIL same_done: done %0b tiles_done %0d want 1 1", done, tiles_done); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; num_tiles = 16'd4; tick();
    start = 1'b0;
    quick_tile(60);
    vecs++; if ({tiles_done, tile_ready} !== {16'd1, 1'b1}) begin miscompares++; $display("FAIL mid_tile1: tiles_done %0d rdy %0b want 1 1", tiles_done, tile_ready); end
    tile_valid = 1'b1; tile_i = pat(70); tile_w = pat(71); tick();
    tile_valid = 1'b0; sh_input_taken = 1'b1; tick();
    sh_input_taken = 1'b0;
    vecs++; if ({busy, sh_state, out_valid} !== 4'b1000) begin miscompares++; $display("FAIL mid_wait: busy/sh/out_valid %b want 1000", {busy, sh_state, out_valid}); end
    reset = 1'b1; tick();
    vecs++; if ({busy, done, err, tile_ready, sh_state, out_valid} !== 7'b0) begin miscompares++; $display("FAIL mid_reset_ctl: %b want 0000000", {busy, done, err, tile_ready, sh_state, out_valid}); end
    vecs++; if ({sh_i, sh_w, out_i, out_w, tiles_done} !== '0) begin miscompares++; $display("FAIL mid_reset_data: sh_i %h out_i %h tiles_done %0d want 0", sh_i, out_i, tiles_done); end
    reset = 1'b0; tick();
    vecs++; if ({busy, out_valid} !== 2'b00) begin miscompares++; $display("FAIL mid_idle: busy/out_valid %b want 00", {busy, out_valid}); end
    start = 1'b1; num_tiles = 16'd2; tick();
    start = 1'b0;
    quick_tile(80);
    vecs++; if ({tiles_done, done} !== {16'd1, 1'b0}) begin miscompares++; $display("FAIL mid_rerun1: tiles_done %0d done %0b want 1 0", tiles_done, done); end
    quick_tile(90);
    vecs++; if ({tiles_done, done} !== {16'd2, 1'b1}) begin miscompares++; $display("FAIL mid_rerun2: tiles_done %0d done %0b want 2 1", tiles_done, done); end
    vecs++; if (out_i !== pat(92)) begin miscompares++; $display("FAIL mid_rerun_data: out_i %h want %h", out_i, pat(92)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_zero();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vecs, miscompares);
    $fatal(1);
  end

endmodule
